// File: rtl/cpu_isa_pkg.sv
// ISA constants, field positions and the decoded-instruction bundle shared by
// the decode stage.
package cpu_isa_pkg;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_XOR  = 6'h05;
  localparam logic [5:0] OP_SLL  = 6'h06;
  localparam logic [5:0] OP_SRL  = 6'h07;
  localparam logic [5:0] OP_ADDI = 6'h10;
  localparam logic [5:0] OP_ANDI = 6'h11;
  localparam logic [5:0] OP_ORI  = 6'h12;
  localparam logic [5:0] OP_LW   = 6'h20;
  localparam logic [5:0] OP_SW   = 6'h21;
  localparam logic [5:0] OP_BEQ  = 6'h30;
  localparam logic [5:0] OP_BNE  = 6'h31;
  localparam logic [5:0] OP_JMP  = 6'h38;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int FA_MSB  = 25;
  localparam int FA_LSB  = 21;
  localparam int FB_MSB  = 20;
  localparam int FB_LSB  = 16;
  localparam int FC_MSB  = 15;
  localparam int FC_LSB  = 11;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        reg_write;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    logic        is_halt;
    logic        illegal;
  } dec_bundle_t;

  typedef enum logic [1:0] {BUF_EMPTY, BUF_ONE, BUF_FULL} buf_state_t;

endpackage

// File: rtl/instruction_decode_unit_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle.
interface instruction_decode_unit_if #(
  parameter int PC_W   = 8,
  parameter int REG_AW = 5
);
  logic              instr_valid;
  logic [31:0]       instr_in;
  logic [PC_W-1:0]   pc_in;
  logic              instr_ready;
  logic              flush;
  logic              out_ready;
  logic              dec_valid;
  logic [5:0]        opcode;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [31:0]       imm;
  logic [PC_W-1:0]   pc_out;
  logic              reg_write;
  logic              is_load;
  logic              is_store;
  logic              is_branch;
  logic              is_jump;
  logic              is_halt;
  logic              illegal;

  modport master (
    output instr_valid, instr_in, pc_in, flush, out_ready,
    input  instr_ready, dec_valid, opcode, rd, rs1, rs2, imm, pc_out,
    input  reg_write, is_load, is_store, is_branch, is_jump, is_halt, illegal
  );

  modport slave (
    input  instr_valid, instr_in, pc_in, flush, out_ready,
    output instr_ready, dec_valid, opcode, rd, rs1, rs2, imm, pc_out,
    output reg_write, is_load, is_store, is_branch, is_jump, is_halt, illegal
  );
endinterface

// File: rtl/instr_field_decoder.sv
// Purely combinational instruction word to decoded bundle.
module instr_field_decoder
  import cpu_isa_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_bundle_t o_bundle
);

  logic [4:0]  w_fa, w_fb, w_fc;
  logic [31:0] w_sext, w_zext;

  assign w_fa   = i_instr[FA_MSB:FA_LSB];
  assign w_fb   = i_instr[FB_MSB:FB_LSB];
  assign w_fc   = i_instr[FC_MSB:FC_LSB];
  assign w_sext = {{16{i_instr[15]}}, i_instr[15:0]};
  assign w_zext = {16'h0000, i_instr[15:0]};

  always_comb begin
    o_bundle        = '0;
    o_bundle.opcode = i_instr[OPC_MSB:OPC_LSB];
    case (o_bundle.opcode)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL: begin
        o_bundle.rd        = w_fa;
        o_bundle.rs1       = w_fb;
        o_bundle.rs2       = w_fc;
        o_bundle.reg_write = 1'b1;
      end
      OP_ADDI, OP_LW: begin
        o_bundle.rd        = w_fa;
        o_bundle.rs1       = w_fb;
        o_bundle.imm       = w_sext;
        o_bundle.reg_write = 1'b1;
        o_bundle.is_load   = (o_bundle.opcode == OP_LW);
      end
      OP_ANDI, OP_ORI: begin
        o_bundle.rd        = w_fa;
        o_bundle.rs1       = w_fb;
        o_bundle.imm       = w_zext;
        o_bundle.reg_write = 1'b1;
      end
      // Stores reuse the rd field as the data-source register.
      OP_SW: begin
        o_bundle.rs1      = w_fb;
        o_bundle.rs2      = w_fa;
        o_bundle.imm      = w_sext;
        o_bundle.is_store = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        o_bundle.rs1       = w_fa;
        o_bundle.rs2       = w_fb;
        o_bundle.imm       = w_sext;
        o_bundle.is_branch = 1'b1;
      end
      OP_JMP: begin
        o_bundle.imm     = {6'b0, i_instr[25:0]};
        o_bundle.is_jump = 1'b1;
      end
      OP_HALT: o_bundle.is_halt = 1'b1;
      default: o_bundle.illegal = 1'b1;
    endcase
    if (o_bundle.rd == 5'd0) o_bundle.reg_write = 1'b0;
  end

endmodule

// File: rtl/instruction_decode_unit.sv
// Decode stage: field decoder feeding a two-entry registered skid buffer with
// flush and a sticky halt.
module instruction_decode_unit
  import cpu_isa_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int REG_AW = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  instruction_decode_unit_if.slave    bus
);

  dec_bundle_t     w_dec;
  dec_bundle_t     r_out_b, r_skid_b;
  logic [PC_W-1:0] r_out_pc, r_skid_pc;
  buf_state_t      r_state, w_state_nx;
  logic            r_halted, r_ready;
  logic            w_accept, w_xfer, w_halted_nx;

  instr_field_decoder u_dec (
    .i_instr  (bus.instr_in),
    .o_bundle (w_dec)
  );

  assign w_accept    = bus.instr_valid && r_ready;
  assign w_xfer      = (r_state != BUF_EMPTY) && bus.out_ready;
  assign w_halted_nx = r_halted || (w_accept && !bus.flush && w_dec.is_halt);

  always_comb begin
    w_state_nx = r_state;
    if (bus.flush) begin
      w_state_nx = BUF_EMPTY;
    end else begin
      case (r_state)
        BUF_EMPTY: if (w_accept) w_state_nx = BUF_ONE;
        BUF_ONE: begin
          if (w_accept && !w_xfer)      w_state_nx = BUF_FULL;
          else if (!w_accept && w_xfer) w_state_nx = BUF_EMPTY;
        end
        BUF_FULL:  if (w_xfer) w_state_nx = BUF_ONE;
        default:   w_state_nx = BUF_EMPTY;
      endcase
    end
  end

  // Ready is derived from the next state so a registered ready never admits an overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= BUF_EMPTY;
      r_halted  <= 1'b0;
      r_ready   <= 1'b1;
      r_out_b   <= '0;
      r_skid_b  <= '0;
      r_out_pc  <= '0;
      r_skid_pc <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_halted <= w_halted_nx;
      r_ready  <= (w_state_nx != BUF_FULL) && !w_halted_nx;
      if (!bus.flush) begin
        if (w_accept && (r_state == BUF_EMPTY || w_xfer)) begin
          r_out_b  <= w_dec;
          r_out_pc <= bus.pc_in;
        end else if (w_accept) begin
          r_skid_b  <= w_dec;
          r_skid_pc <= bus.pc_in;
        end else if (r_state == BUF_FULL && w_xfer) begin
          r_out_b  <= r_skid_b;
          r_out_pc <= r_skid_pc;
        end
      end
    end
  end

  assign bus.instr_ready = r_ready;
  assign bus.dec_valid   = (r_state != BUF_EMPTY);
  assign bus.opcode      = r_out_b.opcode;
  assign bus.rd          = REG_AW'(r_out_b.rd);
  assign bus.rs1         = REG_AW'(r_out_b.rs1);
  assign bus.rs2         = REG_AW'(r_out_b.rs2);
  assign bus.imm         = r_out_b.imm;
  assign bus.pc_out      = r_out_pc;
  assign bus.reg_write   = r_out_b.reg_write;
  assign bus.is_load     = r_out_b.is_load;
  assign bus.is_store    = r_out_b.is_store;
  assign bus.is_branch   = r_out_b.is_branch;
  assign bus.is_jump     = r_out_b.is_jump;
  assign bus.is_halt     = r_out_b.is_halt;
  assign bus.illegal     = r_out_b.illegal;

endmodule

// File: tb/tb_instruction_decode_unit.sv
// Self-checking bench for instruction_decode_unit against a queue-based model.
module tb_instruction_decode_unit;

  typedef logic [67:0] obs_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  obs_t q[$];
  logic m_halted;
  obs_t dut_obs;

  instruction_decode_unit_if #(.PC_W(8), .REG_AW(5)) bus ();

  instruction_decode_unit #(.PC_W(8), .REG_AW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dut_obs = {bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.imm, bus.pc_out,
                    bus.reg_write, bus.is_load, bus.is_store, bus.is_branch,
                    bus.is_jump, bus.is_halt, bus.illegal};

  function automatic obs_t ref_dec(input logic [31:0] w, input logic [7:0] pc);
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        wr, ld, st, br, jp, ht, il;
    op = w[31:26];
    rd = 0; rs1 = 0; rs2 = 0; imm = 0;
    {wr, ld, st, br, jp, ht, il} = 7'b0;
    if (op >= 6'h01 && op <= 6'h07) begin
      rd = w[25:21]; rs1 = w[20:16]; rs2 = w[15:11]; wr = 1;
    end else if (op == 6'h10 || op == 6'h20) begin
      rd = w[25:21]; rs1 = w[20:16]; imm = {{16{w[15]}}, w[15:0]}; wr = 1;
      ld = (op == 6'h20);
    end else if (op == 6'h11 || op == 6'h12) begin
      rd = w[25:21]; rs1 = w[20:16]; imm = {16'h0, w[15:0]}; wr = 1;
    end else if (op == 6'h21) begin
      rs1 = w[20:16]; rs2 = w[25:21]; imm = {{16{w[15]}}, w[15:0]}; st = 1;
    end else if (op == 6'h30 || op == 6'h31) begin
      rs1 = w[25:21]; rs2 = w[20:16]; imm = {{16{w[15]}}, w[15:0]}; br = 1;
    end else if (op == 6'h38) begin
      imm = {6'b0, w[25:0]}; jp = 1;
    end else if (op == 6'h3F) begin
      ht = 1;
    end else if (op != 6'h00) begin
      il = 1;
    end
    if (rd == 0) wr = 0;
    return {op, rd, rs1, rs2, imm, pc, wr, ld, st, br, jp, ht, il};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [5:0] ops[16];
    logic [5:0] op;
    ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
            6'h10, 6'h11, 6'h12, 6'h20, 6'h21, 6'h30, 6'h31, 6'h38};
    if ($urandom_range(0, 3) == 0) op = 6'($urandom);
    else op = ops[$urandom_range(0, 15)];
    if (op == 6'h3F) op = 6'h3A;
    return {op, 26'($urandom)};
  endfunction

  // Drive one cycle of inputs and advance the model across the coming edge.
  task automatic step(input logic v, input logic [31:0] w, input logic [7:0] pc,
                      input logic fl, input logic ordy);
    logic acc;
    logic xfer;
    bus.instr_valid = v;
    bus.instr_in    = w;
    bus.pc_in       = pc;
    bus.flush       = fl;
    bus.out_ready   = ordy;
    acc  = v && !m_halted && (q.size() < 2);
    xfer = (q.size() > 0) && ordy;
    if (xfer) void'(q.pop_front());
    if (fl) q.delete();
    else if (acc) begin
      q.push_back(ref_dec(w, pc));
      if (w[31:26] == 6'h3F) m_halted = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.instr_valid = 0; bus.instr_in = 0; bus.pc_in = 0;
    bus.flush = 0; bus.out_ready = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    m_halted = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.instr_valid = 0; bus.instr_in = 0; bus.pc_in = 0;
    bus.flush = 0; bus.out_ready = 0;
    @(negedge clk);
    n_cmp++; if (bus.dec_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.dec_valid); end
    n_cmp++; if (bus.instr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.instr_ready); end
    n_cmp++; if (dut_obs !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", dut_obs); end
    reset = 1'b0;
    q.delete();
    m_halted = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    obs_t exp_o;
    exp_o = {6'h01, 5'd3, 5'd1, 5'd2, 32'h0, 8'h04, 7'b1000000};
    step(1, 32'h04611000, 8'h04, 0, 1);
    n_cmp++; if (bus.dec_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", bus.dec_valid); end
    n_cmp++; if (dut_obs !== exp_o) begin n_err++; $display("FAIL add_fields: got %h want %h", dut_obs, exp_o); end
    step(0, 0, 0, 0, 1);
    n_cmp++; if (bus.dec_valid !== 1'b0) begin n_err++; $display("FAIL add_drain: got %b want 0", bus.dec_valid); end
  endtask

  task automatic test_imm();
    step(1, 32'h40A0FFFC, 8'h08, 0, 1);
    n_cmp++; if (bus.imm !== 32'hFFFFFFFC) begin n_err++; $display("FAIL addi_imm: got %h want FFFFFFFC", bus.imm); end
    n_cmp++; if (bus.rd !== 5'd5 || bus.reg_write !== 1'b1) begin n_err++; $display("FAIL addi_rd: got rd=%0d wr=%b want 5/1", bus.rd, bus.reg_write); end
    step(1, 32'h48A0FFFC, 8'h0C, 0, 1);
    n_cmp++; if (bus.imm !== 32'h0000FFFC) begin n_err++; $display("FAIL ori_imm: got %h want 0000FFFC", bus.imm); end
    n_cmp++; if (bus.pc_out !== 8'h0C) begin n_err++; $display("FAIL ori_pc: got %h want 0C", bus.pc_out); end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] wa, wb, wc;
    wa = {6'h02, 26'($urandom)};
    wb = {6'h05, 26'($urandom)};
    wc = {6'h03, 26'($urandom)};
    n_cmp++; if (bus.instr_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready0: got %b want 1", bus.instr_ready); end
    step(1, wa, 8'h10, 0, 0);
    n_cmp++; if (bus.instr_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready1: got %b want 1", bus.instr_ready); end
    step(1, wb, 8'h14, 0, 0);
    n_cmp++; if (bus.instr_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready2: got %b want 0", bus.instr_ready); end
    n_cmp++; if (dut_obs !== ref_dec(wa, 8'h10)) begin n_err++; $display("FAIL bp_hold1: got %h want %h", dut_obs, ref_dec(wa, 8'h10)); end
    step(1, wc, 8'h18, 0, 0);
    n_cmp++; if (dut_obs !== ref_dec(wa, 8'h10) || bus.dec_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold2: got %h want %h", dut_obs, ref_dec(wa, 8'h10)); end
    step(0, 0, 0, 0, 1);
    n_cmp++; if (dut_obs !== ref_dec(wb, 8'h14) || bus.dec_valid !== 1'b1) begin n_err++; $display("FAIL bp_second: got %h want %h", dut_obs, ref_dec(wb, 8'h14)); end
    n_cmp++; if (bus.instr_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready3: got %b want 1", bus.instr_ready); end
    step(0, 0, 0, 0, 1);
    n_cmp++; if (bus.dec_valid !== 1'b0) begin n_err++; $display("FAIL bp_nodup: got %b want 0", bus.dec_valid); end
  endtask

  task automatic test_flush();
    step(1, 32'h04611000, 8'h20, 0, 0);
    step(1, 32'h08611000, 8'h24, 0, 0);
    n_cmp++; if (bus.instr_ready !== 1'b0) begin n_err++; $display("FAIL flush_full: got %b want 0", bus.instr_ready); end
    step(1, 32'h0C611000, 8'h28, 1, 0);
    n_cmp++; if (bus.dec_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", bus.dec_valid); end
    n_cmp++; if (bus.instr_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b want 1", bus.instr_ready); end
    step(0, 0, 0, 0, 1);
    n_cmp++; if (bus.dec_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop: got %b want 0", bus.dec_valid); end
  endtask

  task automatic test_special();
    obs_t e;
    step(1, {6'h3A, 26'h3FFFFFF}, 8'h30, 0, 1);
    e = {6'h3A, 5'd0, 5'd0, 5'd0, 32'h0, 8'h30, 7'b0000001};
    n_cmp++; if (dut_obs !== e) begin n_err++; $display("FAIL illegal: got %h want %h", dut_obs, e); end
    step(1, {6'h21, 5'd7, 5'd9, 16'h0010}, 8'h34, 0, 1);
    e = {6'h21, 5'd0, 5'd9, 5'd7, 32'h10, 8'h34, 7'b0010000};
    n_cmp++; if (dut_obs !== e) begin n_err++; $display("FAIL sw_fields: got %h want %h", dut_obs, e); end
    step(1, {6'h01, 5'd0, 5'd1, 5'd2, 11'd0}, 8'h38, 0, 1);
    n_cmp++; if (bus.reg_write !== 1'b0 || bus.dec_valid !== 1'b1) begin n_err++; $display("FAIL add_rd0: got wr=%b v=%b want 0/1", bus.reg_write, bus.dec_valid); end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      n_cmp++;
      if (bus.instr_ready !== (!m_halted && q.size() < 2)) begin
        n_err++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, bus.instr_ready, (!m_halted && q.size() < 2));
      end
      n_cmp++;
      if (bus.dec_valid !== (q.size() > 0)) begin
        n_err++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, bus.dec_valid, (q.size() > 0));
      end else if (q.size() > 0) begin
        n_cmp++;
        if (dut_obs !== q[0]) begin n_err++; $display("FAIL rnd_data[%0d]: got %h want %h", i, dut_obs, q[0]); end
      end
      step($urandom_range(0, 9) < 7, rand_word(), 8'($urandom),
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
    end
  endtask

  task automatic test_halt();
    int seen;
    do_reset();
    seen = 0;
    step(1, 32'hFC000000, 8'h40, 0, 1);
    for (int i = 0; i < 6; i++) begin
      if (bus.dec_valid === 1'b1 && bus.is_halt === 1'b1) seen++;
      n_cmp++; if (bus.instr_ready !== 1'b0) begin n_err++; $display("FAIL halt_ready[%0d]: got %b want 0", i, bus.instr_ready); end
      step(1, {6'h01, 26'($urandom)}, 8'h44, 0, 1);
    end
    n_cmp++; if (seen !== 1) begin n_err++; $display("FAIL halt_once: got %0d want 1", seen); end
    step(1, 32'h04611000, 8'h48, 1, 1);
    n_cmp++; if (bus.instr_ready !== 1'b0) begin n_err++; $display("FAIL halt_flush: got %b want 0", bus.instr_ready); end
    do_reset();
    n_cmp++; if (bus.instr_ready !== 1'b1) begin n_err++; $display("FAIL halt_reset: got %b want 1", bus.instr_ready); end
  endtask

  task automatic test_async_reset();
    step(1, 32'h04611000, 8'h50, 0, 0);
    step(1, 32'h08611000, 8'h54, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.dec_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid: got %b want 0", bus.dec_valid); end
    n_cmp++; if (bus.instr_ready !== 1'b1) begin n_err++; $display("FAIL areset_ready: got %b want 1", bus.instr_ready); end
    n_cmp++; if (dut_obs !== '0) begin n_err++; $display("FAIL areset_data: got %h want 0", dut_obs); end
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    m_halted = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_halted = 1'b0;
    test_reset();
    test_add();
    test_imm();
    test_back_to_back();
    test_flush();
    test_special();
    test_random();
    test_async_reset();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
